// File: rtl/testpattern_mode_ctrl_pkg.sv
// Shared types and constant timing sets for the 27 MHz test-pattern path.
package testpattern_mode_ctrl_pkg;

  localparam int unsigned PARAM_W = 10;
  localparam int unsigned TIMER_W = 20;

  typedef enum logic {
    MODE_480P = 1'b0,
    MODE_576P = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_SWAP       = 2'd2,
    ST_SETTLE     = 2'd3
  } state_e;

  typedef struct packed {
    logic [PARAM_W-1:0] h_synclen;
    logic [PARAM_W-1:0] h_backporch;
    logic [PARAM_W-1:0] h_active;
    logic [PARAM_W-1:0] h_total;
    logic [PARAM_W-1:0] v_synclen;
    logic [PARAM_W-1:0] v_backporch;
    logic [PARAM_W-1:0] v_active;
    logic [PARAM_W-1:0] v_total;
  } timing_t;

  localparam timing_t TIMING_480P = '{
    h_synclen:   10'd62,
    h_backporch: 10'd60,
    h_active:    10'd720,
    h_total:     10'd858,
    v_synclen:   10'd6,
    v_backporch: 10'd30,
    v_active:    10'd480,
    v_total:     10'd525
  };

  localparam timing_t TIMING_576P = '{
    h_synclen:   10'd64,
    h_backporch: 10'd68,
    h_active:    10'd720,
    h_total:     10'd864,
    v_synclen:   10'd5,
    v_backporch: 10'd39,
    v_active:    10'd576,
    v_total:     10'd625
  };

  // Parameter set belonging to a mode.
  function automatic timing_t timing_for(input mode_e mode);
    return (mode == MODE_576P) ? TIMING_576P : TIMING_480P;
  endfunction

endpackage

// File: rtl/testpattern_mode_ctrl_frame_watchdog.sv
// Frame counter plus saturating timeout timer; a timeout stands in for a missing frame_start.
module testpattern_mode_ctrl_frame_watchdog
  import testpattern_mode_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned FRAME_TIMEOUT = 600000,
  localparam int unsigned CNT_W = $clog2(SETTLE_FRAMES + 1)
) (
  input  logic             clk27,
  input  logic             reset,
  input  logic             clear,
  input  logic             count_en,
  input  logic             frame_start,
  output logic             frame_seen,
  output logic             timed_out,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FRAME_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(SETTLE_FRAMES);

  logic [TIMER_W-1:0] timer_q;

  assign frame_seen = count_en & frame_start;
  assign timed_out  = count_en & (timer_q >= TIMER_LAST);

  // Timer restarts on every frame event; frame count and timer both saturate.
  always_ff @(posedge clk27 or posedge reset) begin
    if (reset) begin
      timer_q   <= '0;
      frame_cnt <= '0;
    end else if (clear) begin
      timer_q   <= '0;
      frame_cnt <= '0;
    end else if (count_en) begin
      if (frame_seen || timed_out) begin
        timer_q <= '0;
        if (frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + CNT_W'(1);
      end else if (timer_q != '1) begin
        timer_q <= timer_q + TIMER_W'(1);
      end
    end
  end

endmodule

// File: rtl/testpattern_mode_ctrl.sv
// Mode-switch sequencer: blank, wait for frame boundary, reset generator while swapping, settle, unblank.
module testpattern_mode_ctrl
  import testpattern_mode_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned FRAME_TIMEOUT = 600000
) (
  input  logic               clk27,
  input  logic               reset,
  input  logic               mode_sel,
  input  logic               mode_req,
  input  logic               frame_start,
  output logic               gen_rst,
  output logic               blank,
  output logic               busy,
  output logic               mode_cur,
  output logic [PARAM_W-1:0] h_synclen,
  output logic [PARAM_W-1:0] h_backporch,
  output logic [PARAM_W-1:0] h_active,
  output logic [PARAM_W-1:0] h_total,
  output logic [PARAM_W-1:0] v_synclen,
  output logic [PARAM_W-1:0] v_backporch,
  output logic [PARAM_W-1:0] v_active,
  output logic [PARAM_W-1:0] v_total
);

  localparam int unsigned        CNT_W     = $clog2(SETTLE_FRAMES + 1);
  localparam int unsigned        SWAP_W    = $clog2(RST_CYCLES + 1);
  localparam logic [SWAP_W-1:0]  SWAP_LAST = SWAP_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SETTLE_FRAMES - 1);

  state_e             state_q, state_d;
  mode_e              target_q, target_d;
  mode_e              mode_q, mode_d;
  mode_e              pend_mode_q, pend_mode_d;
  logic               pend_q, pend_d;
  logic [SWAP_W-1:0]  swap_cnt_q, swap_cnt_d;
  timing_t            timing_q, timing_d;
  logic               gen_rst_q, gen_rst_d;
  logic               blank_q, blank_d;
  logic               busy_q, busy_d;

  logic               clear_c;
  logic               count_en_c;
  logic               frame_seen;
  logic               timed_out;
  logic [CNT_W-1:0]   frame_cnt;
  logic               settle_done_c;
  logic               eff_pend_c;
  mode_e              eff_mode_c;
  mode_e              req_mode_c;

  assign count_en_c    = (state_q == ST_WAIT_FRAME) || (state_q == ST_SETTLE);
  assign clear_c       = (state_d != state_q);
  assign settle_done_c = (frame_seen || timed_out) && (frame_cnt == CNT_LAST);
  assign req_mode_c    = mode_e'(mode_sel);
  // A request in the SETTLE exit cycle takes precedence over the stored one.
  assign eff_pend_c    = pend_q | mode_req;
  assign eff_mode_c    = mode_req ? req_mode_c : pend_mode_q;

  testpattern_mode_ctrl_frame_watchdog #(
    .SETTLE_FRAMES (SETTLE_FRAMES),
    .FRAME_TIMEOUT (FRAME_TIMEOUT)
  ) u_frame_watchdog (
    .clk27       (clk27),
    .reset       (reset),
    .clear       (clear_c),
    .count_en    (count_en_c),
    .frame_start (frame_start),
    .frame_seen  (frame_seen),
    .timed_out   (timed_out),
    .frame_cnt   (frame_cnt)
  );

  // Next-state, pending-request and registered-output decode.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    mode_d      = mode_q;
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    swap_cnt_d  = swap_cnt_q;
    timing_d    = timing_q;

    if (mode_req && (state_q != ST_IDLE)) begin
      pend_d      = 1'b1;
      pend_mode_d = req_mode_c;
    end

    case (state_q)
      ST_IDLE: begin
        if (mode_req && (req_mode_c != mode_q)) begin
          target_d = req_mode_c;
          state_d  = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        if (frame_seen || timed_out) begin
          state_d    = ST_SWAP;
          swap_cnt_d = '0;
          mode_d     = target_q;
          timing_d   = timing_for(target_q);
        end
      end
      ST_SWAP: begin
        if (swap_cnt_q == SWAP_LAST) state_d = ST_SETTLE;
        else swap_cnt_d = swap_cnt_q + SWAP_W'(1);
      end
      ST_SETTLE: begin
        if (settle_done_c) begin
          pend_d = 1'b0;
          if (eff_pend_c && (eff_mode_c != mode_q)) begin
            target_d = eff_mode_c;
            state_d  = ST_WAIT_FRAME;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_SETTLE;
    endcase

    gen_rst_d = (state_d == ST_SWAP);
    blank_d   = (state_d != ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and output registers; reset lands in SETTLE with 480p driven.
  always_ff @(posedge clk27 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SETTLE;
      target_q    <= MODE_480P;
      mode_q      <= MODE_480P;
      pend_q      <= 1'b0;
      pend_mode_q <= MODE_480P;
      swap_cnt_q  <= '0;
      timing_q    <= TIMING_480P;
      gen_rst_q   <= 1'b0;
      blank_q     <= 1'b1;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      swap_cnt_q  <= swap_cnt_d;
      timing_q    <= timing_d;
      gen_rst_q   <= gen_rst_d;
      blank_q     <= blank_d;
      busy_q      <= busy_d;
    end
  end

  assign gen_rst     = gen_rst_q;
  assign blank       = blank_q;
  assign busy        = busy_q;
  assign mode_cur    = mode_q;
  assign h_synclen   = timing_q.h_synclen;
  assign h_backporch = timing_q.h_backporch;
  assign h_active    = timing_q.h_active;
  assign h_total     = timing_q.h_total;
  assign v_synclen   = timing_q.v_synclen;
  assign v_backporch = timing_q.v_backporch;
  assign v_active    = timing_q.v_active;
  assign v_total     = timing_q.v_total;

endmodule

// File: tb/tb_testpattern_mode_ctrl.sv
// Randomized bench for testpattern_mode_ctrl against a cycle-level behavioural model.
module tb_testpattern_mode_ctrl;

  localparam int unsigned SF       = 2;
  localparam int unsigned RC       = 4;
  localparam int unsigned TO       = 300;
  localparam int          N_CYCLES = 60000;

  logic       clk27 = 1'b0;
  logic       reset, mode_sel, mode_req, frame_start;
  logic       gen_rst, blank, busy, mode_cur;
  logic [9:0] h_synclen, h_backporch, h_active, h_total;
  logic [9:0] v_synclen, v_backporch, v_active, v_total;

  testpattern_mode_ctrl #(
    .SETTLE_FRAMES (SF),
    .RST_CYCLES    (RC),
    .FRAME_TIMEOUT (TO)
  ) dut (
    .clk27       (clk27),
    .reset       (reset),
    .mode_sel    (mode_sel),
    .mode_req    (mode_req),
    .frame_start (frame_start),
    .gen_rst     (gen_rst),
    .blank       (blank),
    .busy        (busy),
    .mode_cur    (mode_cur),
    .h_synclen   (h_synclen),
    .h_backporch (h_backporch),
    .h_active    (h_active),
    .h_total     (h_total),
    .v_synclen   (v_synclen),
    .v_backporch (v_backporch),
    .v_active    (v_active),
    .v_total     (v_total)
  );

  always #5 clk27 = ~clk27;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Timing table for a mode, straight from the mode definitions.
  function automatic logic [79:0] exp_params(input bit m);
    int t[8];
    if (m) t = '{64, 68, 720, 864, 5, 39, 576, 625};
    else   t = '{62, 60, 720, 858, 6, 30, 480, 525};
    return {10'(t[0]), 10'(t[1]), 10'(t[2]), 10'(t[3]),
            10'(t[4]), 10'(t[5]), 10'(t[6]), 10'(t[7])};
  endfunction

  // Model: phase 0 idle, 1 waiting for frame, 2 swapping, 3 settling.
  int ph, wcnt, frames, swleft;
  bit cur, tgt, pend, pmode;

  task automatic model_step(input bit rst, input bit req, input bit sel, input bit fs);
    bit tick;
    if (rst) begin
      ph = 3; wcnt = 0; frames = 0; swleft = 0;
      cur = 0; tgt = 0; pend = 0; pmode = 0;
      return;
    end
    case (ph)
      0: begin
        if (req && sel != cur) begin tgt = sel; ph = 1; wcnt = 0; end
      end
      1: begin
        if (req) begin pend = 1; pmode = sel; end
        wcnt++;
        if (fs || wcnt == TO) begin ph = 2; cur = tgt; swleft = RC; end
      end
      2: begin
        if (req) begin pend = 1; pmode = sel; end
        swleft--;
        if (swleft == 0) begin ph = 3; frames = 0; wcnt = 0; end
      end
      default: begin
        wcnt++;
        tick = fs || (wcnt == TO);
        if (tick) begin frames++; wcnt = 0; end
        if (frames == SF) begin
          if (req) begin pend = 1; pmode = sel; end
          if (pend && pmode != cur) begin tgt = pmode; ph = 1; wcnt = 0; end
          else ph = 0;
          pend = 0;
        end else if (req) begin
          pend = 1; pmode = sel;
        end
      end
    endcase
  endtask

  int  fp, fcnt, seg_left, req_div;
  bit  p_rst, p_req, p_sel, p_fs;
  logic [83:0] got_v, exp_v;

  initial begin
    reset = 1'b1; mode_req = 1'b0; mode_sel = 1'b0; frame_start = 1'b0;
    p_rst = 1; p_req = 0; p_sel = 0; p_fs = 0;
    fp = 0; fcnt = 0; seg_left = 0; req_div = 150;
    ph = 3; wcnt = 0; frames = 0; swleft = 0; cur = 0; tgt = 0; pend = 0; pmode = 0;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(posedge clk27);
      #1;
      model_step(p_rst, p_req, p_sel, p_fs);
      got_v = {gen_rst, blank, busy, mode_cur,
               h_synclen, h_backporch, h_active, h_total,
               v_synclen, v_backporch, v_active, v_total};
      exp_v = {(ph == 2), (ph != 0), (ph != 0), cur, exp_params(cur)};
      check($sformatf("cyc%0d", cyc), 128'(got_v), 128'(exp_v));

      // New stimulus segment: frame cadence (0 = frame_start tied low) and request density.
      if (seg_left == 0) begin
        seg_left = $urandom_range(500, 3000);
        fp       = ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(40, 420);
        fcnt     = 0;
        req_div  = ($urandom_range(0, 3) == 0) ? 20 : 150;
      end
      seg_left--;

      p_fs  = (fp != 0) && (fcnt == fp - 1);
      fcnt  = p_fs ? 0 : fcnt + 1;
      p_req = ($urandom_range(0, req_div - 1) == 0);
      p_sel = 1'($urandom_range(0, 1));
      p_rst = (cyc < 3) || (ph == 2 && $urandom_range(0, 9) == 0) ||
              ($urandom_range(0, 19999) == 0);

      reset       = p_rst;
      mode_req    = p_req;
      mode_sel    = p_sel;
      frame_start = p_fs;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
